aurora_rx_stream_filter: RTL
============================

Name: aurora_rx_stream_filter

Overview:
- Sits on USER_CLK directly upstream of the RD53B histogrammer.
- Takes the raw 64-bit Aurora RX word stream, discards service (user-K) frames, orphan continuation frames and frames from unselected chip IDs, and forwards only clean RD53B data-stream frames.
- Output is registered with a start-of-stream marker.
- Saturating statistics counters are exposed for the bus register block.

Parameters:
- TIMEOUT_W, 16, width of the inter-frame idle timeout counter.
- CNT_W, 32, width of each statistics counter.

Ports:
- USER_CLK  in  1  Aurora user clock; the only clock.
- USER_RST  in  1  reset, asynchronous, active-high.
- ENABLE  in  1  0 = drop everything and force IDLE.
- CHIP_ID_EN  in  1  1 = filter streams on chip ID.
- CHIP_ID  in  2  chip ID to accept.
- TIMEOUT  in  TIMEOUT_W  idle cycles before an open stream is closed; 0 = never.
- AURORA_RX_TDATA  in  64  raw frame; bit 63 = NS (new stream), bits 62:61 = chip ID on NS frames.
- AURORA_RX_TVALID  in  1  frame valid.
- AURORA_RX_TUSER  in  1  1 = service/register frame.
- OUT_TDATA  out  64  filtered frame.
- OUT_TVALID  out  1  filtered frame valid.
- OUT_SOS  out  1  qualifies OUT_TVALID; frame is first of a stream.
- CNT_PASSED  out  CNT_W  frames forwarded.
- CNT_DROPPED  out  CNT_W  frames discarded (all causes).
- CNT_STREAMS  out  CNT_W  streams accepted.
- CNT_TIMEOUTS  out  CNT_W  streams closed by timeout.

Behaviour:
- Reset values: all outputs 0; state IDLE; idle counter 0.
- Latency: exactly 1 cycle, input word to output word. No backpressure; every valid input is either forwarded or dropped in its cycle.
- Input classification (only when TVALID=1):
  - SVC: TUSER=1.
  - NSF: TUSER=0 and bit63=1.
  - CONT: TUSER=0 and bit63=0.
- ID match: CHIP_ID_EN=0, or bits[62:61]==CHIP_ID.
- States: IDLE, STREAM, SKIP.
  - IDLE: NSF with ID match -> pass, SOS=1, STREAMS++, go to STREAM. NSF without match -> drop, go to SKIP. CONT -> drop (orphan), stay.
  - STREAM: CONT -> pass, SOS=0. NSF with match -> pass, SOS=1, STREAMS++, stay (previous stream ends implicitly). NSF without match -> drop, go to SKIP.
  - SKIP: CONT -> drop. NSF -> evaluated as in IDLE.
- SVC frames: always dropped; never change state and never reset the idle counter.
- Idle counter:
  - Runs in STREAM and SKIP.
  - Cleared on any non-SVC valid frame; increments otherwise, saturating at the top value.
  - When TIMEOUT!=0 and counter==TIMEOUT-1 with no non-SVC frame this cycle: next state IDLE. TIMEOUTS++ only if leaving STREAM.
  - A frame arriving in the same cycle as expiry wins: it is processed normally and the timeout does not fire.
- ENABLE=0: state forced to IDLE next cycle; all valid frames dropped and counted as dropped; OUT_TVALID=0 from the next cycle.
- CHIP_ID or CHIP_ID_EN changing mid-stream affects only subsequent NSF frames.
- Counters saturate at all-ones and never wrap. Passed + dropped equals the number of valid inputs until saturation.
- OUT_TDATA holds its last value when OUT_TVALID=0.
- Reset mid-stream: immediate return to IDLE; the next CONT is an orphan and is dropped.

Optional Feature:
- Macro: HIST53B_STREAM_FILTER_STATS_EN.
- Defined: the four counters are implemented as above.
- Undefined: counter logic is removed and CNT_* are tied to 0.
- Filtering and stream behaviour are identical either way.

Decomposition:
- Shared package (hist53b_pkg):
  - State enum {IDLE, STREAM, SKIP}.
  - Constants: NS_BIT=63, CHIP_ID_MSB=62, CHIP_ID_LSB=61.
  - Frame class enum {SVC, NSF, CONT, NONE}.
- Sub-module sat_counter (parameter W; inputs inc, clk, rst): instantiated four times.

Test Plan:
- NSF 0x8000_0000_0000_0001, then CONT 0x0000_0000_0000_0002 and 0x...03 -> three outputs 1 cycle later; SOS=1 on first only; PASSED=3, STREAMS=1.
- From reset, CONT 0x...05, then NSF -> CONT dropped (DROPPED=1); NSF passed with SOS=1.
- CHIP_ID_EN=1, CHIP_ID=2: NSF with bits62:61=1 then 2 CONT -> all dropped (DROPPED=3); next NSF with bits=2 -> passed, SOS=1.
- Interleave SVC frames (TUSER=1, bit63=1) inside a stream -> SVC dropped; continuation frames still pass; no new SOS; STREAMS unchanged.
- TIMEOUT=4: NSF, then 4 idle cycles, then CONT -> CONT dropped, TIMEOUTS=1. Repeat with the CONT on the 4th idle cycle -> CONT passed, TIMEOUTS unchanged.
- ENABLE dropped mid-stream, then raised, then CONT -> CONT dropped as orphan; preload counters near all-ones and drive extra frames -> counters stick at 0xFFFF_FFFF.

Source files
------------

// File: rtl/hist53b_pkg.sv
// Shared types and frame-field positions for the RD53B histogrammer front end.
package hist53b_pkg;

  typedef enum logic [1:0] {IDLE, STREAM, SKIP} state_t;
  typedef enum logic [1:0] {SVC, NSF, CONT, NONE} frame_cls_t;

  localparam int unsigned NS_BIT      = 63;
  localparam int unsigned CHIP_ID_MSB = 62;
  localparam int unsigned CHIP_ID_LSB = 61;

  function automatic frame_cls_t classify(input logic valid, input logic user, input logic ns);
    if (!valid)    return NONE;
    else if (user) return SVC;
    else if (ns)   return NSF;
    else           return CONT;
  endfunction

endpackage

// File: rtl/aurora_rx_stream_filter_sat_counter.sv
// Saturating up-counter used for the stream filter statistics.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (inc && (count != '1))
      count <= count + 1'b1;
  end

endmodule

// File: rtl/aurora_rx_stream_filter.sv
// Aurora RX stream filter: forwards clean RD53B data-stream frames with a registered SOS marker.
// Statistics counters are built only when HIST53B_STREAM_FILTER_STATS_EN is defined.
module aurora_rx_stream_filter #(
  parameter int unsigned TIMEOUT_W = 16,
  parameter int unsigned CNT_W     = 32
) (
  input  logic                 USER_CLK,
  input  logic                 USER_RST,
  input  logic                 ENABLE,
  input  logic                 CHIP_ID_EN,
  input  logic [1:0]           CHIP_ID,
  input  logic [TIMEOUT_W-1:0] TIMEOUT,
  input  logic [63:0]          AURORA_RX_TDATA,
  input  logic                 AURORA_RX_TVALID,
  input  logic                 AURORA_RX_TUSER,
  output logic [63:0]          OUT_TDATA,
  output logic                 OUT_TVALID,
  output logic                 OUT_SOS,
  output logic [CNT_W-1:0]     CNT_PASSED,
  output logic [CNT_W-1:0]     CNT_DROPPED,
  output logic [CNT_W-1:0]     CNT_STREAMS,
  output logic [CNT_W-1:0]     CNT_TIMEOUTS
);

  import hist53b_pkg::*;

  state_t               state, nxt_state;
  frame_cls_t           cls;
  logic                 id_match, pass, sos, timeout_fire;
  logic [TIMEOUT_W-1:0] idle_cnt, nxt_idle;

  always_comb begin
    cls       = classify(AURORA_RX_TVALID, AURORA_RX_TUSER, AURORA_RX_TDATA[NS_BIT]);
    id_match  = !CHIP_ID_EN || (AURORA_RX_TDATA[CHIP_ID_MSB:CHIP_ID_LSB] == CHIP_ID);
    pass      = 1'b0;
    sos       = 1'b0;
    nxt_state = state;
    nxt_idle  = idle_cnt;
    // Expiry only fires in a cycle with no non-SVC frame, so a same-cycle frame wins.
    timeout_fire = ENABLE && (state != IDLE) && ((cls == SVC) || (cls == NONE)) &&
                   (TIMEOUT != '0) && (idle_cnt == TIMEOUT - 1'b1);
    if (!ENABLE) begin
      nxt_state = IDLE;
      nxt_idle  = '0;
    end else begin
      case (cls)
        NSF: begin
          nxt_idle = '0;
          if (id_match) begin
            pass      = 1'b1;
            sos       = 1'b1;
            nxt_state = STREAM;
          end else begin
            nxt_state = SKIP;
          end
        end
        CONT: begin
          nxt_idle = '0;
          pass     = (state == STREAM);
        end
        default: begin
          if (timeout_fire) begin
            nxt_state = IDLE;
            nxt_idle  = '0;
          end else if ((state != IDLE) && (idle_cnt != '1)) begin
            nxt_idle = idle_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge USER_CLK or posedge USER_RST) begin
    if (USER_RST) begin
      state      <= IDLE;
      idle_cnt   <= '0;
      OUT_TDATA  <= '0;
      OUT_TVALID <= 1'b0;
      OUT_SOS    <= 1'b0;
    end else begin
      state      <= nxt_state;
      idle_cnt   <= nxt_idle;
      OUT_TVALID <= pass;
      OUT_SOS    <= sos;
      if (pass)
        OUT_TDATA <= AURORA_RX_TDATA;
    end
  end

`ifdef HIST53B_STREAM_FILTER_STATS_EN
  logic dropped_inc, timeouts_inc;
  assign dropped_inc  = AURORA_RX_TVALID & ~pass;
  assign timeouts_inc = timeout_fire & (state == STREAM);

  sat_counter #(.W(CNT_W)) u_cnt_passed (
    .clk(USER_CLK), .rst(USER_RST), .inc(pass), .count(CNT_PASSED));
  sat_counter #(.W(CNT_W)) u_cnt_dropped (
    .clk(USER_CLK), .rst(USER_RST), .inc(dropped_inc), .count(CNT_DROPPED));
  sat_counter #(.W(CNT_W)) u_cnt_streams (
    .clk(USER_CLK), .rst(USER_RST), .inc(sos), .count(CNT_STREAMS));
  sat_counter #(.W(CNT_W)) u_cnt_timeouts (
    .clk(USER_CLK), .rst(USER_RST), .inc(timeouts_inc), .count(CNT_TIMEOUTS));
`else
  assign CNT_PASSED   = '0;
  assign CNT_DROPPED  = '0;
  assign CNT_STREAMS  = '0;
  assign CNT_TIMEOUTS = '0;
`endif

endmodule
